// File: rtl/axi_pkg.sv
// Shared AXI definitions: BRESP codes and the write error-responder state type.
package axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DRAIN_W  = 2'd1,
        ST_WAIT_REQ = 2'd2,
        ST_RESP_B   = 2'd3
    } wr_err_state_e;

endpackage

// File: rtl/axi_wr_error_responder.sv
// Error slave for unroutable AXI writes: captures AWID/AWLEN, sinks the W burst, returns one DECERR B beat.
// Latency: completion pulse in the same cycle as the final W beat; bvalid one cycle after error_req_i.
// Backpressure: W accepted only while handle_error_i is high; B held stable until bready_i.
module axi_wr_error_responder
    import axi_pkg::*;
#(
    parameter int         ID_WIDTH  = 4,
    parameter int         LEN_WIDTH = 8,
    parameter logic [1:0] ERR_RESP  = RESP_DECERR
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 sample_awdata_info_i,
    input  logic [ID_WIDTH-1:0]  awid_i,
    input  logic [LEN_WIDTH-1:0] awlen_i,
    input  logic                 handle_error_i,
    input  logic                 wvalid_i,
    input  logic                 wlast_i,
    output logic                 wready_o,
    output logic                 wdata_error_completed_o,
    input  logic                 error_req_i,
    output logic                 error_gnt_o,
    output logic [ID_WIDTH-1:0]  bid_o,
    output logic [1:0]           bresp_o,
    output logic                 bvalid_o,
    input  logic                 bready_i,
    output logic                 wlast_mismatch_o
);

    wr_err_state_e        state, state_nxt;
    logic [ID_WIDTH-1:0]  awid_q;
    logic [LEN_WIDTH-1:0] awlen_q;
    logic [LEN_WIDTH:0]   cnt;
    logic                 mismatch_q;
    logic                 capture;
    logic                 beat;
    logic                 last_by_cnt;

    // cnt holds beats accepted so far, so the current beat is the final one when cnt == awlen.
    assign capture     = (state == ST_IDLE) && sample_awdata_info_i;
    assign beat        = wvalid_i && wready_o;
    assign last_by_cnt = (cnt == {1'b0, awlen_q});

    assign wlast_mismatch_o = mismatch_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            awid_q     <= '0;
            awlen_q    <= '0;
            cnt        <= '0;
            mismatch_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (capture) begin
                awid_q     <= awid_i;
                awlen_q    <= awlen_i;
                cnt        <= '0;
                mismatch_q <= 1'b0;
            end else if (beat) begin
                cnt <= cnt + (LEN_WIDTH+1)'(1);
                if (wlast_i != last_by_cnt) begin
                    mismatch_q <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_nxt               = state;
        wready_o                = 1'b0;
        wdata_error_completed_o = 1'b0;
        error_gnt_o             = 1'b0;
        bvalid_o                = 1'b0;
        bid_o                   = '0;
        bresp_o                 = '0;
        unique case (state)
            ST_IDLE: begin
                if (sample_awdata_info_i) state_nxt = ST_DRAIN_W;
            end
            ST_DRAIN_W: begin
                wready_o = handle_error_i;
                if (wvalid_i && handle_error_i && (wlast_i || last_by_cnt)) begin
                    wdata_error_completed_o = 1'b1;
                    state_nxt               = ST_WAIT_REQ;
                end
            end
            ST_WAIT_REQ: begin
                if (error_req_i) state_nxt = ST_RESP_B;
            end
            ST_RESP_B: begin
                bvalid_o    = 1'b1;
                bid_o       = awid_q;
                bresp_o     = ERR_RESP;
                error_gnt_o = bready_i;
                if (bready_i) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Tracks whether the current captured transaction has already signalled completion.
    logic done_seen;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                       done_seen <= 1'b0;
        else if (capture)                 done_seen <= 1'b0;
        else if (wdata_error_completed_o) done_seen <= 1'b1;
    end

    a_bvalid_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (bvalid_o && !bready_i) |=> (bvalid_o && $stable(bid_o) && $stable(bresp_o)));

    a_wready_drain_only: assert property (@(posedge clk) disable iff (!rst_n)
        wready_o |-> (state == ST_DRAIN_W));

    a_one_completion: assert property (@(posedge clk) disable iff (!rst_n)
        wdata_error_completed_o |-> !done_seen);

    a_sample_in_idle: assert property (@(posedge clk) disable iff (!rst_n)
        sample_awdata_info_i |-> (state == ST_IDLE));

endmodule
